// File: rtl/motion_seg_sequencer.sv
// Segment queue and sequencer feeding the asg/apg pair. Queued segments are
// issued back-to-back on asg_done without host involvement.
module motion_seg_sequencer #(
  parameter int DEPTH_LOG2 = 3,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_stb,
  input  logic [DATA_W-1:0]     wr_steps,
  input  logic [DATA_W-1:0]     wr_dt,
  input  logic [DATA_W-1:0]     wr_a,
  input  logic [DATA_W-1:0]     wr_j,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  clear_errors,
  input  logic                  asg_done,
  input  logic                  asg_abort,
  output logic [DATA_W-1:0]     steps_val,
  output logic [DATA_W-1:0]     dt_val,
  output logic [DATA_W-1:0]     a_val,
  output logic [DATA_W-1:0]     j_val,
  output logic                  load,
  output logic [5:0]            ctl,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  complete,
  output logic                  aborted
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     stepsMem [DEPTH];
  logic [DATA_W-1:0]     dtMem    [DEPTH];
  logic [DATA_W-1:0]     aMem     [DEPTH];
  logic [DATA_W-1:0]     jMem     [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_q, rdPtr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, empty_q, overflow_q, overflow_d;
  logic [DATA_W-1:0]     stepsVal_q, dtVal_q, aVal_q, jVal_q;
  logic                  load_q, busy_q, complete_q, aborted_q;
  logic [5:0]            ctl_q;

  logic flush, push, pop, bypass, loadValues, completeSet, abortedSet;

  // A host abort flushes from any state; asg_abort only matters while sequencing.
  assign flush  = (state_q == IDLE) ? abort : (abort | asg_abort);
  assign push   = wr_stb & ~full_q & ~flush;
  assign pop    = (state_q == ISSUE) & ~flush;
  assign bypass = empty_q & push;

  always_comb begin
    state_d     = state_q;
    loadValues  = 1'b0;
    completeSet = 1'b0;
    abortedSet  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && start && !empty_q) begin
          state_d    = ISSUE;
          loadValues = 1'b1;
        end
      end
      ISSUE: begin
        if (flush) begin
          state_d    = IDLE;
          abortedSet = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d    = IDLE;
          abortedSet = 1'b1;
        end else if (asg_done) begin
          if (!empty_q || push) begin
            state_d    = ISSUE;
            loadValues = 1'b1;
          end else begin
            state_d     = IDLE;
            completeSet = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (flush)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CNT_ONE;
    else if (!push && pop)
      count_d = count_q - CNT_ONE;
  end

  // An overflowing write outranks a coincident clear.
  always_comb begin
    overflow_d = overflow_q;
    if (clear_errors)
      overflow_d = 1'b0;
    if (wr_stb && full_q)
      overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      stepsMem[wrPtr_q] <= wr_steps;
      dtMem[wrPtr_q]    <= wr_dt;
      aMem[wrPtr_q]     <= wr_a;
      jMem[wrPtr_q]     <= wr_j;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      stepsVal_q <= '0;
      dtVal_q    <= '0;
      aVal_q     <= '0;
      jVal_q     <= '0;
      load_q     <= 1'b0;
      ctl_q      <= '0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      full_q     <= (count_d == CNT_FULL);
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_d;
      if (flush) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
      end else begin
        if (push) wrPtr_q <= wrPtr_q + PTR_ONE;
        if (pop)  rdPtr_q <= rdPtr_q + PTR_ONE;
      end
      // A segment written while the queue is empty is forwarded straight to the buses.
      if (loadValues) begin
        stepsVal_q <= bypass ? wr_steps : stepsMem[rdPtr_q];
        dtVal_q    <= bypass ? wr_dt    : dtMem[rdPtr_q];
        aVal_q     <= bypass ? wr_a     : aMem[rdPtr_q];
        jVal_q     <= bypass ? wr_j     : jMem[rdPtr_q];
      end
      load_q     <= (state_q == ISSUE);
      ctl_q      <= (state_q == ISSUE) ? 6'h3F : 6'h00;
      busy_q     <= (state_d != IDLE);
      complete_q <= completeSet;
      aborted_q  <= abortedSet;
    end
  end

  assign steps_val = stepsVal_q;
  assign dt_val    = dtVal_q;
  assign a_val     = aVal_q;
  assign j_val     = jVal_q;
  assign load      = load_q;
  assign ctl       = ctl_q;
  assign busy      = busy_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign complete  = complete_q;
  assign aborted   = aborted_q;

endmodule
